// File: rtl/alu_mc.sv
// Multi-cycle ALU: saturating add/sub with pre-shift, Q-format multiply, and MAC into acc.
// Latency is 1 cycle for add/sub/clr/reserved and DW+1 cycles for mul/mac; start is ignored while busy.
module alu_mc #(
    parameter int DW       = 16,
    parameter int ADD_SAT  = 12,
    parameter int MUL_FRAC = 12,
    parameter int MUL_SAT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic          sat,
    input  logic [1:0]    shamt,
    input  logic [DW-1:0] src0,
    input  logic [DW-1:0] src1,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          ovf,
    output logic [DW-1:0] acc
);

    localparam int XW = 2*DW + 2;
    localparam int CW = $clog2(DW + 1);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_MAC    = 3'b011;
    localparam logic [2:0] OP_ACCCLR = 3'b100;

    localparam logic signed [XW-1:0] ADD_MAX = XW'((64'sd1 <<< (ADD_SAT-1)) - 64'sd1);
    localparam logic signed [XW-1:0] ADD_MIN = XW'(-(64'sd1 <<< (ADD_SAT-1)));
    localparam logic signed [XW-1:0] MUL_MAX = XW'((64'sd1 <<< (MUL_SAT-1)) - 64'sd1);
    localparam logic signed [XW-1:0] MUL_MIN = XW'(-(64'sd1 <<< (MUL_SAT-1)));

    typedef enum logic [1:0] {IDLE, ADD, MUL, FIN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_r;
    logic            sat_r;
    logic [1:0]      shamt_r;
    logic [DW-1:0]   src0_r, src1_r;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] prod;

    function automatic logic [DW-1:0] clamp_dw(input logic signed [XW-1:0] v,
                                               input logic signed [XW-1:0] lo,
                                               input logic signed [XW-1:0] hi);
        if (v > hi) return hi[DW-1:0];
        if (v < lo) return lo[DW-1:0];
        return v[DW-1:0];
    endfunction

    function automatic logic out_of(input logic signed [XW-1:0] v,
                                    input logic signed [XW-1:0] lo,
                                    input logic signed [XW-1:0] hi);
        return (v > hi) || (v < lo);
    endfunction

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (op == OP_MUL || op == OP_MAC) ? MUL : ADD;
            ADD:  state_d = IDLE;
            MUL:  if (cnt == CW'(DW-1)) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic signed [XW-1:0] src0_x, src1_x, shifted, add_sum;
    logic [DW-1:0]        add_val;
    logic                 add_ovf;
    logic [DW-1:0]        mag0, mag1_in;
    logic [DW:0]          part;
    logic signed [XW-1:0] p_mag, p, q, mac_sum;
    logic [DW-1:0]        mul_val, mac_val;
    logic                 mul_ovf, mac_ovf;

    always_comb begin
        src0_x  = {{(XW-DW){src0_r[DW-1]}}, src0_r};
        src1_x  = {{(XW-DW){src1_r[DW-1]}}, src1_r};
        shifted = src0_x <<< shamt_r;
        add_sum = (op_r == OP_SUB) ? (src1_x + ~shifted + XW'(1)) : (src1_x + shifted);
        add_val = clamp_dw(add_sum, ADD_MIN, ADD_MAX);
        add_ovf = out_of(add_sum, ADD_MIN, ADD_MAX);

        // Shift-add on magnitudes; the sign is reapplied once the product is complete.
        mag0    = src0_r[DW-1] ? -src0_r : src0_r;
        mag1_in = src1[DW-1] ? -src1 : src1;
        part    = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, mag0} : '0);

        p_mag   = {2'b00, prod};
        p       = (src0_r[DW-1] ^ src1_r[DW-1]) ? -p_mag : p_mag;
        q       = p >>> MUL_FRAC;
        mul_val = clamp_dw(q, MUL_MIN, MUL_MAX);
        mul_ovf = out_of(q, MUL_MIN, MUL_MAX);

        mac_sum = {{(XW-DW){acc[DW-1]}}, acc} + {{(XW-DW){mul_val[DW-1]}}, mul_val};
        mac_ovf = sat_r && out_of(mac_sum, ADD_MIN, ADD_MAX);
        mac_val = sat_r ? clamp_dw(mac_sum, ADD_MIN, ADD_MAX) : mac_sum[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            prod    <= '0;
            op_r    <= '0;
            sat_r   <= 1'b0;
            shamt_r <= '0;
            src0_r  <= '0;
            src1_r  <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    op_r    <= op;
                    sat_r   <= sat;
                    shamt_r <= shamt;
                    src0_r  <= src0;
                    src1_r  <= src1;
                    cnt     <= '0;
                    prod    <= {{DW{1'b0}}, mag1_in};
                end
                ADD: begin
                    done <= 1'b1;
                    case (op_r)
                        OP_ADD, OP_SUB: begin
                            result <= sat_r ? add_val : add_sum[DW-1:0];
                            ovf    <= sat_r && add_ovf;
                        end
                        OP_ACCCLR: begin
                            acc    <= '0;
                            result <= '0;
                            ovf    <= 1'b0;
                        end
                        default: begin
                            result <= '0;
                            ovf    <= 1'b0;
                        end
                    endcase
                end
                MUL: begin
                    prod <= {part, prod[DW-1:1]};
                    cnt  <= cnt + CW'(1);
                end
                FIN: begin
                    done <= 1'b1;
                    if (op_r == OP_MAC) begin
                        acc    <= mac_val;
                        result <= mac_val;
                        ovf    <= mul_ovf || mac_ovf;
                    end else begin
                        result <= mul_val;
                        ovf    <= mul_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
